// File: rtl/ean13_scan_controller_if.sv
// Publish channel from the scan controller to the downstream code consumer.
// oCode/oCodeValid flow towards the consumer, iCodeReady flows back.
interface ean13_scan_controller_if;
    logic [51:0] oCode;
    logic        oCodeValid;
    logic        iCodeReady;

    // A transfer completes on any clock edge where oCodeValid and iCodeReady
    // are both high. oCode holds steady while oCodeValid=1 and iCodeReady=0.
    modport master (
        output oCode,
        output oCodeValid,
        input  iCodeReady
    );

    modport slave (
        input  oCode,
        input  oCodeValid,
        output iCodeReady
    );
endinterface

// File: rtl/ean13_scan_controller.sv
// EAN-13 frame controller: gates the scan band, checksum-validates each decode,
// majority-votes the valid codes and publishes the winner at every frame close.
module ean13_scan_controller #(
    parameter int V_TOTAL         = 24,
    parameter int SCAN_LINE_FIRST = 0,
    parameter int SCAN_LINE_LAST  = 15,
    parameter int MIN_VOTES       = 3,
    parameter int VOTE_WIDTH      = 5,
    localparam int VW             = $clog2(V_TOTAL) + 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFrameStart,
    input  logic [VW-1:0]         iVpixel,
    input  logic                  iNewData,
    input  logic [51:0]           iDataCode,
    output logic                  oScanEnable,
    output logic [VOTE_WIDTH-1:0] oVotes,
    output logic [7:0]            oErrCount,
    output logic                  oOverrun,
    output logic [1:0]            oState,
    ean13_scan_controller_if.master code_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        VOTE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [51:0]           cand_q, cand_d;
    logic [7:0]            sum_q, sum_d;
    logic [3:0]            k_q, k_d;
    logic                  bad_q, bad_d;
    logic [51:0]           leader_q, leader_d;
    logic [VOTE_WIDTH-1:0] votes_q, votes_d;
    logic [7:0]            err_frame_q, err_frame_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [51:0]           code_q, code_d;
    logic                  code_valid_q, code_valid_d;
    logic                  scan_en_q, scan_en_d;
    logic                  overrun_q, overrun_d;

    logic [5:0]            nib_lsb;
    logic [3:0]            nib;
    logic                  pass;
    logic                  slot_free;

    // State register and all datapath flops
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            bad_q        <= 1'b0;
            leader_q     <= '0;
            votes_q      <= '0;
            err_frame_q  <= '0;
            err_count_q  <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            scan_en_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            sum_q        <= sum_d;
            k_q          <= k_d;
            bad_q        <= bad_d;
            leader_q     <= leader_d;
            votes_q      <= votes_d;
            err_frame_q  <= err_frame_d;
            err_count_q  <= err_count_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            scan_en_q    <= scan_en_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state logic; a frame close abandons any candidate still being checked
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (iNewData) state_d = CHECK;
            end
            CHECK: begin
                if (iFrameStart)       state_d = IDLE;
                else if (k_q == 4'd12) state_d = VOTE;
            end
            VOTE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit k sits at nibble 12-k, so digit 0 is the top nibble
    assign nib_lsb   = {(4'd12 - k_q), 2'b00};
    assign nib       = cand_q[nib_lsb +: 4];
    assign pass      = !bad_q && (sum_q % 8'd10 == 8'd0);
    assign slot_free = !code_valid_q || code_if.iCodeReady;

    // Datapath and outputs
    always_comb begin
        cand_d       = cand_q;
        sum_d        = sum_q;
        k_d          = k_q;
        bad_d        = bad_q;
        leader_d     = leader_q;
        votes_d      = votes_q;
        err_frame_d  = err_frame_q;
        err_count_d  = err_count_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        overrun_d    = 1'b0;
        scan_en_d    = (int'(iVpixel) >= SCAN_LINE_FIRST) &&
                       (int'(iVpixel) <= SCAN_LINE_LAST);

        case (state_q)
            IDLE: begin
                if (iNewData) begin
                    cand_d = iDataCode;
                    sum_d  = '0;
                    k_d    = '0;
                    bad_d  = 1'b0;
                end
            end
            CHECK: begin
                if (nib > 4'd9) bad_d = 1'b1;
                sum_d = sum_q + {4'b0000, nib} +
                        (k_q[0] ? {3'b000, nib, 1'b0} : 8'd0);
                k_d   = k_q + 4'd1;
                if (iNewData) overrun_d = 1'b1;
            end
            VOTE: begin
                if (iNewData) overrun_d = 1'b1;
                if (!pass) begin
                    if (err_frame_q != 8'hFF) err_frame_d = err_frame_q + 8'd1;
                end else if (cand_q == leader_q) begin
                    if (votes_q != '1) votes_d = votes_q + 1'b1;
                end else if (votes_q == '0) begin
                    leader_d = cand_q;
                    votes_d  = {{(VOTE_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    votes_d = votes_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (code_valid_q && code_if.iCodeReady) code_valid_d = 1'b0;

        // Frame close sees this cycle's vote/error update
        if (iFrameStart) begin
            if (int'(votes_d) >= MIN_VOTES) begin
                if (slot_free) begin
                    code_d       = leader_d;
                    code_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            err_count_d = err_frame_d;
            err_frame_d = '0;
            leader_d    = '0;
            votes_d     = '0;
        end
    end

    assign oScanEnable        = scan_en_q;
    assign oVotes             = votes_q;
    assign oErrCount          = err_count_q;
    assign oOverrun           = overrun_q;
    assign oState             = state_q;
    assign code_if.oCode      = code_q;
    assign code_if.oCodeValid = code_valid_q;

endmodule

// File: tb/tb_ean13_scan_controller.sv
// Directed bench for ean13_scan_controller: two instances (MIN_VOTES=3 with a
// 4..9 scan band, MIN_VOTES=1 with defaults) share the stimulus.
module tb_ean13_scan_controller;

  localparam logic [51:0] CODE_A  = 52'h4006381333931;
  localparam logic [51:0] CODE_B  = 52'h5901234123457;
  localparam logic [51:0] CODE_AX = 52'h4006381333932;
  localparam logic [51:0] CODE_F  = 52'hF006381333931;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [5:0]  vpixel = '0;
  logic        new_data = 1'b0;
  logic [51:0] data_code = '0;
  logic        ready = 1'b0;
  logic        ready1 = 1'b1;

  logic        scan_en, scan_en1;
  logic [4:0]  votes, votes1;
  logic [7:0]  err_count, err_count1;
  logic        overrun, overrun1;
  logic [1:0]  state, state1;

  int n_tests = 0;
  int n_fail = 0;
  logic [51:0] exp_q[$];

  ean13_scan_controller_if cif();
  ean13_scan_controller_if cif1();
  assign cif.iCodeReady  = ready;
  assign cif1.iCodeReady = ready1;

  ean13_scan_controller #(
    .V_TOTAL(24), .SCAN_LINE_FIRST(4), .SCAN_LINE_LAST(9), .MIN_VOTES(3), .VOTE_WIDTH(5)
  ) u_dut (
    .iClk(clk), .iRst(rst), .iFrameStart(frame_start), .iVpixel(vpixel),
    .iNewData(new_data), .iDataCode(data_code), .oScanEnable(scan_en),
    .oVotes(votes), .oErrCount(err_count), .oOverrun(overrun), .oState(state),
    .code_if(cif)
  );

  ean13_scan_controller #(
    .V_TOTAL(24), .SCAN_LINE_FIRST(0), .SCAN_LINE_LAST(15), .MIN_VOTES(1), .VOTE_WIDTH(5)
  ) u_dut1 (
    .iClk(clk), .iRst(rst), .iFrameStart(frame_start), .iVpixel(vpixel),
    .iNewData(new_data), .iDataCode(data_code), .oScanEnable(scan_en1),
    .oVotes(votes1), .oErrCount(err_count1), .oOverrun(overrun1), .oState(state1),
    .code_if(cif1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One decode pulse, then wait until its vote has landed (edge t+14, sampled #1 after)
  task automatic send_code(input logic [51:0] c);
    @(negedge clk);
    new_data  = 1'b1;
    data_code = c;
    @(negedge clk);
    new_data  = 1'b0;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic close_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(cif.oCodeValid), 64'd0);
    check("rst_code", 64'(cif.oCode), 64'd0);
    check("rst_votes", 64'(votes), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_scan", 64'(scan_en), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Checksum pass, MIN_VOTES=1 instance publishes
    send_code(CODE_A);
    check("pass_votes1", 64'(votes1), 64'd1);
    check("pass_votes", 64'(votes), 64'd1);
    close_frame();
    exp_q.push_back(CODE_A);
    check("pass_valid1", 64'(cif1.oCodeValid), 64'd1);
    check("pass_code1", 64'(cif1.oCode), 64'(exp_q.pop_front()));
    check("pass_err1", 64'(err_count1), 64'd0);
    check("pass_nopub_min3", 64'(cif.oCodeValid), 64'd0);

    // Checksum fail x3
    for (int i = 0; i < 3; i++) begin
      send_code(CODE_AX);
      check("fail_votes", 64'(votes), 64'd0);
    end
    close_frame();
    check("fail_nopub", 64'(cif.oCodeValid), 64'd0);
    check("fail_err", 64'(err_count), 64'd3);

    // Unresolved leading digit
    send_code(CODE_F);
    close_frame();
    check("bad_nib_err", 64'(err_count), 64'd1);

    // Majority A,A,B,A,A with the consumer stalled
    ready = 1'b0;
    send_code(CODE_A);
    send_code(CODE_A);
    send_code(CODE_B);
    check("maj_after_b", 64'(votes), 64'd1);
    send_code(CODE_A);
    send_code(CODE_A);
    check("maj_votes", 64'(votes), 64'd3);
    close_frame();
    exp_q.push_back(CODE_A);
    check("maj_valid", 64'(cif.oCodeValid), 64'd1);
    check("maj_code", 64'(cif.oCode), 64'(exp_q[0]));
    check("maj_err", 64'(err_count), 64'd0);

    // Second qualifying frame while the slot is still full
    for (int i = 0; i < 3; i++) begin
      send_code(CODE_B);
      check("bp_code_stable", 64'(cif.oCode), 64'(exp_q[0]));
    end
    check("bp_votes", 64'(votes), 64'd3);
    close_frame();
    check("bp_overrun", 64'(overrun), 64'd1);
    check("bp_valid_held", 64'(cif.oCodeValid), 64'd1);
    check("bp_code_kept", 64'(cif.oCode), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    check("bp_overrun_pulse", 64'(overrun), 64'd0);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(cif.oCodeValid), 64'd0);
    @(negedge clk);
    ready = 1'b0;

    // A,B,A,B cancels out
    send_code(CODE_A);
    send_code(CODE_B);
    send_code(CODE_A);
    send_code(CODE_B);
    check("abab_votes", 64'(votes), 64'd0);
    close_frame();
    check("abab_nopub", 64'(cif.oCodeValid), 64'd0);

    // Second decode five cycles into a check is dropped
    @(negedge clk);
    new_data  = 1'b1;
    data_code = CODE_A;
    @(negedge clk);
    new_data = 1'b0;
    repeat (4) @(negedge clk);
    new_data  = 1'b1;
    data_code = CODE_B;
    @(posedge clk);
    #1;
    check("busy_overrun", 64'(overrun), 64'd1);
    check("busy_state", 64'(state), 64'd1);
    @(negedge clk);
    new_data = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_votes", 64'(votes), 64'd1);
    check("busy_overrun_end", 64'(overrun), 64'd0);
    close_frame();

    // Frame start mid-CHECK abandons the candidate (passing, then failing one)
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      new_data  = 1'b1;
      data_code = (r == 0) ? CODE_A : CODE_AX;
      @(negedge clk);
      new_data = 1'b0;
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      check("abandon_idle", 64'(state), 64'd0);
      repeat (15) @(posedge clk);
      #1;
      check("abandon_votes", 64'(votes), 64'd0);
    end
    close_frame();
    check("abandon_err", 64'(err_count), 64'd0);

    // Scan band 4..9, one cycle of latency
    for (int v = 0; v < 24; v++) begin
      @(negedge clk);
      vpixel = 6'(v);
      if (v > 0) check("scan_late", 64'(scan_en), 64'((v - 1 >= 4) && (v - 1 <= 9)));
      @(posedge clk);
      #1;
      check("scan_en", 64'(scan_en), 64'((v >= 4) && (v <= 9)));
    end

    // Asynchronous reset while a code is pending
    send_code(CODE_A);
    send_code(CODE_A);
    send_code(CODE_A);
    close_frame();
    check("pre_rst_valid", 64'(cif.oCodeValid), 64'd1);
    @(negedge clk);
    send_code(CODE_B);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(cif.oCodeValid), 64'd0);
    check("arst_code", 64'(cif.oCode), 64'd0);
    check("arst_votes", 64'(votes), 64'd0);
    check("arst_err", 64'(err_count), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    check("arst_ovr", 64'(overrun), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ean13_scan_controller.md
# ean13_scan_controller

Frame-level controller for the EAN-13 line scanner. It restricts scanning to a configurable band of video lines and checksum-validates every per-line decode result. It majority-votes the valid results across a frame and, at each frame boundary, publishes one confirmed 13-digit code on a valid/ready interface to the downstream consumer (display overlay / host register bank).

## Interface
Parameters:
- V_TOTAL, 24, total lines per frame; sets line-index width VW = CLOG2(V_TOTAL)+1.
- SCAN_LINE_FIRST, 0, first line on which scanning is enabled.
- SCAN_LINE_LAST, 15, last line on which scanning is enabled (inclusive).
- MIN_VOTES, 3, minimum winning vote count for a code to be published.
- VOTE_WIDTH, 5, width of vote counter; counter saturates at 2^VOTE_WIDTH-1.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset, asynchronous, active-high.
- iFrameStart  in  1  one-cycle pulse at start of each frame; closes the previous frame.
- iVpixel  in  VW  current line index from the scanner.
- iNewData  in  1  one-cycle pulse: iDataCode holds a fresh decode.
- iDataCode  in  52  13 BCD nibbles; [51:48] is digit 0 (leading), [3:0] is digit 12 (check digit).
- oScanEnable  out  1  high while the current line is inside the scan band; gates the scanner's iPixelActive.
- oCode  out  52  published code; stable while oCodeValid is high.
- oCodeValid  out  1  published code available.
- iCodeReady  in  1  consumer accepts oCode.
- oVotes  out  VOTE_WIDTH  current leader vote count (live).
- oErrCount  out  8  checksum failures in the last closed frame, saturating at 255.
- oOverrun  out  1  one-cycle pulse when a result is lost (busy drop or publish blocked).

## Operation
- FSM states: IDLE, CHECK, VOTE.
- IDLE:
  - On iNewData, capture iDataCode into the candidate register.
  - Clear the sum accumulator and digit index; go to CHECK.
- CHECK: 13 cycles, digit index k = 0..12, one nibble per cycle.
  - Any nibble > 9 sets the bad flag; this includes the 0xF that marks an unresolved leading digit.
  - Sum += nibble × (k even ? 1 : 3).
  - The sum is 8 bits; the maximum is 225, so it never overflows.
  - After k = 12, go to VOTE.
- VOTE: one cycle. The candidate passes if the bad flag is clear and sum mod 10 = 0.
  - Fail: the frame error count increments (saturating); return to IDLE.
  - Pass, candidate = leader: votes increments (saturating).
  - Pass, candidate ≠ leader, votes = 0: leader ← candidate, votes ← 1.
  - Pass, candidate ≠ leader, votes > 0: votes decrements (Boyer-Moore majority).
  - Return to IDLE.
- iNewData while in CHECK or VOTE: the result is dropped and oOverrun pulses.
- Frame close on iFrameStart:
  - Publish condition: votes ≥ MIN_VOTES and the output slot is free. The slot is free when oCodeValid = 0, or when iCodeReady = 1 in the same cycle.
  - If the condition holds, oCode ← leader and oCodeValid ← 1.
  - If votes ≥ MIN_VOTES but the slot is not free, the code is discarded and oOverrun pulses.
  - In all cases: oErrCount ← frame error count; the frame error count, leader and votes clear.
- iFrameStart during CHECK: the in-flight candidate is abandoned, with no vote and no error count; the FSM goes to IDLE.
- iFrameStart during VOTE: the same-cycle vote/error update is included in the frame-close evaluation and in oErrCount.
- oScanEnable ← (SCAN_LINE_FIRST ≤ iVpixel ≤ SCAN_LINE_LAST).

## Timing
- Reset values:
  - State IDLE.
  - oCode = 0, oCodeValid = 0, oScanEnable = 0, oVotes = 0, oErrCount = 0, oOverrun = 0.
  - Leader = 0.
- iNewData sampled at edge t: CHECK occupies t+1..t+13 and VOTE occupies t+14. oVotes reflects the result from t+15.
- The controller accepts a new result every 15 cycles; it is busy from the capture edge through the VOTE cycle.
- oScanEnable has one cycle of latency from iVpixel.
- Publish: oCodeValid/oCode update on the edge after the iFrameStart cycle.
- Handshake: transfer completes on any edge where oCodeValid and iCodeReady are both high. oCodeValid falls on that edge unless a publish occurs in the same cycle.
- oCode must not change while oCodeValid = 1 and iCodeReady = 0.
- Reset mid-frame: all state clears immediately and any pending output is lost.

## Test plan
- Checksum pass:
  - Stimulus: one iNewData with 52'h4006381333931, then iFrameStart, MIN_VOTES = 1.
  - Required: oVotes = 1 at t+15; oCodeValid = 1 with oCode = 52'h4006381333931; oErrCount = 0.
- Checksum fail:
  - Stimulus: 52'h4006381333932 ×3, then iFrameStart.
  - Required: oVotes stays 0; no publish; oErrCount = 3.
- Bad nibble:
  - Stimulus: 52'hF006381333931, then iFrameStart.
  - Required: counted as an error; oErrCount = 1.
- Majority vote, MIN_VOTES = 3:
  - Stimulus: results A,A,B,A,A (A = 4006381333931, B = 5901234123457).
  - Required: leader A, votes = 3, A published.
  - Stimulus: A,B,A,B.
  - Required: votes = 0, no publish.
- Backpressure:
  - Stimulus: iCodeReady held 0 across two qualifying frames.
  - Required: the first code stays stable; the second is discarded with an oOverrun pulse.
  - Stimulus: raise iCodeReady.
  - Required: oCodeValid falls on the next edge.
- Boundaries:
  - Stimulus: iNewData 5 cycles after a prior iNewData.
  - Required: dropped, oOverrun pulse.
  - Stimulus: iFrameStart mid-CHECK.
  - Required: candidate abandoned, no vote or error counted.
  - Stimulus: sweep iVpixel 0..V_TOTAL-1 with SCAN_LINE_FIRST = 4, SCAN_LINE_LAST = 9.
  - Required: oScanEnable high for lines 4..9 only, one cycle late.
  - Stimulus: iRst asserted with oCodeValid = 1.
  - Required: all outputs return to 0 immediately.
